// File: rtl/cavlc_coeff_scan.sv
// CAVLC coefficient scanner: walks a captured 4x4 zig-zag block from the
// highest index down, producing totalcoeff, trailing ones and totalzero.
module cavlc_coeff_scan #(
  parameter int COEF_W = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [COEF_W-1:0] din_00,
  input  logic signed [COEF_W-1:0] din_01,
  input  logic signed [COEF_W-1:0] din_02,
  input  logic signed [COEF_W-1:0] din_03,
  input  logic signed [COEF_W-1:0] din_04,
  input  logic signed [COEF_W-1:0] din_05,
  input  logic signed [COEF_W-1:0] din_06,
  input  logic signed [COEF_W-1:0] din_07,
  input  logic signed [COEF_W-1:0] din_08,
  input  logic signed [COEF_W-1:0] din_09,
  input  logic signed [COEF_W-1:0] din_10,
  input  logic signed [COEF_W-1:0] din_11,
  input  logic signed [COEF_W-1:0] din_12,
  input  logic signed [COEF_W-1:0] din_13,
  input  logic signed [COEF_W-1:0] din_14,
  input  logic signed [COEF_W-1:0] din_15,
  output logic                     busy,
  output logic                     done,
  output logic [4:0]               totalcoeff,
  output logic [1:0]               trailing_ones,
  output logic [2:0]               t1_sign,
  output logic [3:0]               totalzero,
  output logic [3:0]               rightmost_index
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state;
  logic signed [COEF_W-1:0] din_a  [16];
  logic signed [COEF_W-1:0] coef_q [16];
  logic [3:0]               idx;
  logic                     found;
  logic                     t1_open;
  logic signed [COEF_W-1:0] cur;
  logic                     nz;
  logic                     pm1;

  assign din_a[0]  = din_00;
  assign din_a[1]  = din_01;
  assign din_a[2]  = din_02;
  assign din_a[3]  = din_03;
  assign din_a[4]  = din_04;
  assign din_a[5]  = din_05;
  assign din_a[6]  = din_06;
  assign din_a[7]  = din_07;
  assign din_a[8]  = din_08;
  assign din_a[9]  = din_09;
  assign din_a[10] = din_10;
  assign din_a[11] = din_11;
  assign din_a[12] = din_12;
  assign din_a[13] = din_13;
  assign din_a[14] = din_14;
  assign din_a[15] = din_15;

  // +/-1 is judged on the full signed word; -1 is all ones
  assign cur = coef_q[idx];
  assign nz  = (cur != '0);
  assign pm1 = (cur == COEF_W'(1)) || (cur == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      idx             <= '0;
      found           <= 1'b0;
      t1_open         <= 1'b0;
      totalcoeff      <= '0;
      trailing_ones   <= '0;
      t1_sign         <= '0;
      totalzero       <= '0;
      rightmost_index <= '0;
      for (int i = 0; i < 16; i++) coef_q[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < 16; i++) coef_q[i] <= din_a[i];
            state           <= SCAN;
            busy            <= 1'b1;
            idx             <= 4'd15;
            found           <= 1'b0;
            t1_open         <= 1'b1;
            totalcoeff      <= '0;
            trailing_ones   <= '0;
            t1_sign         <= '0;
            totalzero       <= '0;
            rightmost_index <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (nz) begin
            totalcoeff <= totalcoeff + 5'd1;
            if (!found) begin
              found           <= 1'b1;
              rightmost_index <= idx;
            end
            if (t1_open) begin
              if (pm1 && trailing_ones != 2'd3) begin
                trailing_ones          <= trailing_ones + 2'd1;
                t1_sign[trailing_ones] <= cur[COEF_W-1];
              end else begin
                t1_open <= 1'b0;
              end
            end
          end else if (found) begin
            totalzero <= totalzero + 4'd1;
          end
          if (idx == 4'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
